// File: rtl/pipe_rca_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_rca_addsub
//  Brief    : Pipelined ripple-carry adder/subtractor with valid/ready flow
//             control. Optional signed-overflow output is enabled by the
//             macro PIPE_RCA_OVF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_rca_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPE_RCA_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int c_CHUNK = WIDTH / STAGES;

    logic             w_stall;
    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;

    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_cy;

    logic [WIDTH-1:0]  w_opa   [STAGES];
    logic [WIDTH-1:0]  w_opb   [STAGES];
    logic [WIDTH-1:0]  w_sprev [STAGES];
    logic [WIDTH-1:0]  w_snext [STAGES];
    logic [c_CHUNK:0]  w_add   [STAGES];
    logic [STAGES-1:0] w_ci;
    logic [STAGES-1:0] w_vin;

    assign w_stall   = r_vld[STAGES-1] && !out_ready;
    assign w_en      = !w_stall;
    assign in_ready  = !w_stall;

    // Subtraction is folded into the operand: a + ~b + ~c_in.
    assign w_b_eff = sub ? ~b : b;
    assign w_c_eff = c_in ^ sub;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign w_opa[k]   = a;
                assign w_opb[k]   = w_b_eff;
                assign w_ci[k]    = w_c_eff;
                assign w_sprev[k] = '0;
                assign w_vin[k]   = in_valid;
            end else begin : g_rest
                assign w_opa[k]   = r_a[k-1];
                assign w_opb[k]   = r_b[k-1];
                assign w_ci[k]    = r_cy[k-1];
                assign w_sprev[k] = r_sum[k-1];
                assign w_vin[k]   = r_vld[k-1];
            end

            assign w_add[k] = {1'b0, w_opa[k][k*c_CHUNK +: c_CHUNK]}
                            + {1'b0, w_opb[k][k*c_CHUNK +: c_CHUNK]}
                            + {{c_CHUNK{1'b0}}, w_ci[k]};

            // Bits at and above this chunk are still zero in the partial sum.
            assign w_snext[k] = w_sprev[k]
                              | (WIDTH'(w_add[k][c_CHUNK-1:0]) << (k * c_CHUNK));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld[k] <= 1'b0;
                    r_cy[k]  <= 1'b0;
                    r_sum[k] <= '0;
                    r_a[k]   <= '0;
                    r_b[k]   <= '0;
                end else if (w_en) begin
                    r_vld[k] <= w_vin[k];
                    // Data only moves with a valid token so the output holds
                    // the last real result across bubbles.
                    if (w_vin[k]) begin
                        r_cy[k]  <= w_add[k][c_CHUNK];
                        r_sum[k] <= w_snext[k];
                        r_a[k]   <= w_opa[k];
                        r_b[k]   <= w_opb[k];
                    end
                end
            end
        end
    endgenerate

    assign sum       = r_sum[STAGES-1];
    assign c_out     = r_cy[STAGES-1];
    assign out_valid = r_vld[STAGES-1];

`ifdef PIPE_RCA_OVF_EN
    logic w_msb_cin;
    logic w_ovf;
    logic r_ovf;

    // Carry into the MSB cell recovered from its sum bit.
    assign w_msb_cin = w_opa[STAGES-1][WIDTH-1] ^ w_opb[STAGES-1][WIDTH-1]
                     ^ w_add[STAGES-1][c_CHUNK-1];
    assign w_ovf     = w_msb_cin ^ w_add[STAGES-1][c_CHUNK];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_en && w_vin[STAGES-1]) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_rca_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_rca_addsub
//  Brief    : Self-checking bench for pipe_rca_addsub (WIDTH=16, STAGES=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_rca_addsub;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         out_valid;
    logic         out_ready = 1'b1;
`ifdef PIPE_RCA_OVF_EN
    logic         overflow;
`endif

    pipe_rca_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .c_out     (c_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PIPE_RCA_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sb;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    res_t exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic on the operands.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        logic [W:0] t;
        longint     sx, sy, sr;
        res_t       r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            t  = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, ~ci};
            sr = sx - sy - longint'(ci);
        end else begin
            t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            sr = sx + sy + longint'(ci);
        end
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (sr > 32767) || (sr < -32768);
        return r;
    endfunction

    // Scoreboard: record accepted inputs, compare completed outputs in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_sum", sum, e.s);
                    check("sb_cout", c_out, e.c);
`ifdef PIPE_RCA_OVF_EN
                    check("sb_ovf", overflow, e.o);
`endif
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, c_in, sub));
        end
    end

    task automatic apply_vec(input vec_t v);
        @(posedge clk); #1;
        a = v.a; b = v.b; c_in = v.ci; sub = v.sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_early", out_valid, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            check("lat_early", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        check("vec_valid", out_valid, 1'b1);
        check("vec_sum", sum, v.es);
        check("vec_cout", c_out, v.ec);
`ifdef PIPE_RCA_OVF_EN
        check("vec_ovf", overflow, v.eo);
`endif
    endtask

    vec_t         tbl [8];
    logic [W-1:0] held;
    int           idx, got, nstall;
    bit           prev_stall;

    initial begin
        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", c_out, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 8; i++) apply_vec(tbl[i]);

        // Bubbles 1,0,1,0
        @(posedge clk); #1;
        a = 16'h0011; b = 16'h0022; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1; a = 16'h0100; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1; check("bubble_0", out_valid, 1'b1);
        @(posedge clk); #1; check("bubble_1", out_valid, 1'b0);
        @(posedge clk); #1; check("bubble_2", out_valid, 1'b1);
        @(posedge clk); #1; check("bubble_3", out_valid, 1'b0);

        // Back-pressure: 8 back-to-back inputs, consumer stalls 3 cycles
        idx = 0; got = 0; nstall = 0; prev_stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (idx < 8) begin
                a = 16'h1000 + 16'(idx * 16'h0111); b = 16'h0101;
                c_in = idx[0]; sub = idx[1]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid && !out_ready) begin
                nstall++;
                check("bp_in_ready", in_ready, 1'b0);
                if (prev_stall) check("bp_sum_held", sum, held);
                held = sum;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) got++;
        end
        check("bp_stall_cycles", nstall, 3);
        check("bp_accepted", idx, 8);
        check("bp_results", got, 8);

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a = 16'h0AAA + 16'(i); b = 16'h0555; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sum", sum, 16'h0000);
        check("midrst_cout", c_out, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("no_stale", out_valid, 1'b0);
        end
        apply_vec(tbl[0]);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            a = W'($urandom); b = W'($urandom);
            c_in = 1'($urandom); sub = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
